// File: rtl/nios_system_s_jtag_debug_host.sv
// System-clock virtual-JTAG initiator driving the Nios II debug module slave side.
// Optional macro JTAG_DEBUG_HOST_IR_CACHE_EN skips the UIR period when the IR is unchanged.
//
// state | meaning
// IDLE  | waiting for a command, tck held low, rti high
// UIR   | one tck period presenting ir_in, samples target IR status
// CDR   | one tck period capture-DR
// SDR   | DR_WIDTH tck periods shifting tdi out / tdo in, LSB first
// UDR   | one tck period update-DR
// RESP  | one clk, rsp_valid pulse with the captured word
module nios_system_s_jtag_debug_host #(
    parameter int TCK_DIV  = 2,
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);

    localparam int PW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RESP
    } state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       phase, phase_nx;
    logic [BW-1:0]       bit_cnt, bit_cnt_nx;
    logic [DR_WIDTH-1:0] sr, sr_nx;
    logic [DR_WIDTH-1:0] rsp_dr_nx;
    logic [IR_WIDTH-1:0] ir_in_nx, rsp_ir_out_nx;
    logic                tck_nx, tdi_nx, rsp_valid_nx;
    logic                phase_end, rise, fall, skip_uir;

`ifdef JTAG_DEBUG_HOST_IR_CACHE_EN
    logic                cache_vld;
    logic [IR_WIDTH-1:0] cache_ir;

    // Cache reflects the IR most recently presented through a full UIR period.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cache_vld <= 1'b0;
            cache_ir  <= '0;
        end else if (state == S_UIR && fall) begin
            cache_vld <= 1'b1;
            cache_ir  <= vji_ir_in;
        end
    end

    assign skip_uir = cache_vld && (cmd_ir == cache_ir);
`else
    assign skip_uir = 1'b0;
`endif

    always_comb begin
        phase_end     = (phase == PW'(TCK_DIV - 1));
        rise          = phase_end & ~vji_tck;
        fall          = phase_end & vji_tck;
        state_nx      = state;
        phase_nx      = phase;
        tck_nx        = vji_tck;
        bit_cnt_nx    = bit_cnt;
        sr_nx         = sr;
        tdi_nx        = vji_tdi;
        ir_in_nx      = vji_ir_in;
        rsp_valid_nx  = 1'b0;
        rsp_dr_nx     = rsp_dr;
        rsp_ir_out_nx = rsp_ir_out;

        if (state == S_UIR || state == S_CDR || state == S_SDR || state == S_UDR) begin
            phase_nx = phase_end ? '0 : phase + PW'(1);
            if (phase_end) tck_nx = ~vji_tck;
        end

        case (state)
            S_IDLE: begin
                phase_nx = '0;
                tck_nx   = 1'b0;
                tdi_nx   = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    ir_in_nx   = cmd_ir;
                    sr_nx      = cmd_dr;
                    bit_cnt_nx = '0;
                    state_nx   = skip_uir ? S_CDR : S_UIR;
                end
            end
            S_UIR: begin
                if (fall) begin
                    rsp_ir_out_nx = vji_ir_out;
                    state_nx      = S_CDR;
                end
            end
            S_CDR: begin
                if (fall) begin
                    tdi_nx   = sr[0];
                    state_nx = S_SDR;
                end
            end
            S_SDR: begin
                if (rise) sr_nx = {vji_tdo, sr[DR_WIDTH-1:1]};
                // sr has already shifted at the rising edge, so sr[0] is the next bit
                if (fall) begin
                    if (bit_cnt == BW'(DR_WIDTH - 1)) begin
                        bit_cnt_nx = '0;
                        tdi_nx     = 1'b0;
                        state_nx   = S_UDR;
                    end else begin
                        bit_cnt_nx = bit_cnt + BW'(1);
                        tdi_nx     = sr[0];
                    end
                end
            end
            S_UDR: begin
                if (fall) begin
                    rsp_dr_nx    = sr;
                    rsp_valid_nx = 1'b1;
                    state_nx     = S_RESP;
                end
            end
            S_RESP: begin
                phase_nx = '0;
                tck_nx   = 1'b0;
                state_nx = S_IDLE;
            end
            default: begin
                phase_nx = '0;
                tck_nx   = 1'b0;
                tdi_nx   = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            phase      <= '0;
            bit_cnt    <= '0;
            sr         <= '0;
            vji_tck    <= 1'b0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            rsp_valid  <= 1'b0;
            rsp_dr     <= '0;
            rsp_ir_out <= '0;
            cmd_ready  <= 1'b1;
            vji_rti    <= 1'b1;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            bit_cnt    <= bit_cnt_nx;
            sr         <= sr_nx;
            vji_tck    <= tck_nx;
            vji_tdi    <= tdi_nx;
            vji_ir_in  <= ir_in_nx;
            rsp_valid  <= rsp_valid_nx;
            rsp_dr     <= rsp_dr_nx;
            rsp_ir_out <= rsp_ir_out_nx;
            cmd_ready  <= (state_nx == S_IDLE);
            vji_rti    <= (state_nx == S_IDLE) || (state_nx == S_RESP);
            vji_uir    <= (state_nx == S_UIR);
            vji_cdr    <= (state_nx == S_CDR);
            vji_sdr    <= (state_nx == S_SDR);
            vji_udr    <= (state_nx == S_UDR);
        end
    end

endmodule

// File: tb/tb_nios_system_s_jtag_debug_host.sv
// Directed bench for nios_system_s_jtag_debug_host with a small virtual-JTAG target model.
// Expectations follow JTAG_DEBUG_HOST_IR_CACHE_EN when the macro is defined.
module tb_nios_system_s_jtag_debug_host;

    localparam int IR_W = 2;
    localparam int DR_W = 38;
`ifdef JTAG_DEBUG_HOST_IR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam int M_LOOP   = 0;
    localparam int M_FIRST1 = 1;
    localparam int M_ZERO   = 2;
    localparam int M_ONES   = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_dr;
    logic            rsp_valid;
    logic [DR_W-1:0] rsp_dr;
    logic [IR_W-1:0] rsp_ir_out;
    logic            vji_tck, vji_tdi, vji_tdo;
    logic [IR_W-1:0] vji_ir_in, vji_ir_out;
    logic            vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;

    nios_system_s_jtag_debug_host #(.TCK_DIV(2), .IR_WIDTH(IR_W), .DR_WIDTH(DR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_rti(vji_rti), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr)
    );

    always #5 clk = ~clk;

    // Target model: records tdi on rising tck, loopback presents it on the following falling tck.
    int              mode = M_ZERO;
    int              tdi_idx = 0;
    logic [DR_W-1:0] tdi_cap = '0;
    logic            lb = 1'b0;
    logic            lb_out = 1'b0;

    always @(posedge vji_tck) begin
        if (vji_cdr) tdi_idx = 0;
        if (vji_sdr && tdi_idx < DR_W) begin
            tdi_cap[tdi_idx] = vji_tdi;
            tdi_idx++;
        end
        lb = vji_tdi;
    end

    always @(negedge vji_tck) lb_out = lb;

    assign vji_tdo = (mode == M_LOOP)   ? lb_out :
                     (mode == M_ONES)   ? 1'b1 :
                     (mode == M_FIRST1) ? (tdi_idx == 0) : 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int   uir_f, uir_l, cdr_f, cdr_l, sdr_f, sdr_l, udr_f, udr_l;
    logic [IR_W-1:0] ir_at1;

    task automatic run_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                           output int lat, output int acc_wait, output logic rv_after);
        logic acc;
        int   cnt;
        @(negedge clk);
        cmd_ir    = ir;
        cmd_dr    = dr;
        cmd_valid = 1'b1;
        acc       = 1'b0;
        acc_wait  = 0;
        rv_after  = 1'b0;
        while (!acc && acc_wait < 8) begin
            acc = cmd_ready;
            @(posedge clk);
            #1;
            acc_wait++;
            if (acc_wait == 1) rv_after = rsp_valid;
        end
        cmd_valid = 1'b0;
        check("accept", {63'd0, acc}, 64'd1);
        uir_f = -1; uir_l = -1; cdr_f = -1; cdr_l = -1;
        sdr_f = -1; sdr_l = -1; udr_f = -1; udr_l = -1;
        ir_at1 = vji_ir_in;
        lat = -1;
        cnt = 1;
        while (cnt <= 400) begin
            if (vji_uir) begin if (uir_f < 0) uir_f = cnt; uir_l = cnt; end
            if (vji_cdr) begin if (cdr_f < 0) cdr_f = cnt; cdr_l = cnt; end
            if (vji_sdr) begin if (sdr_f < 0) sdr_f = cnt; sdr_l = cnt; end
            if (vji_udr) begin if (udr_f < 0) udr_f = cnt; udr_l = cnt; end
            if (rsp_valid) begin
                lat = cnt;
                break;
            end
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    typedef struct {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] dr;
        int              mode;
        logic [IR_W-1:0] ir_out;
        logic [DR_W-1:0] exp_dr;
    } vec_t;

    vec_t            vecs[6];
    int              lat, acc_wait, off;
    logic            rv_after, skip;
    logic            m_vld;
    logic [IR_W-1:0] m_ir, m_ir_out;
    int              rv_seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_ir     = '0;
        cmd_dr     = '0;
        vji_ir_out = '0;

        vecs[0] = '{2'b01, 38'h15_5555_AAAA, M_LOOP,   2'b00, 38'h2A_AAAB_5554};
        vecs[1] = '{2'b11, 38'h3F_0F0F_1234, M_FIRST1, 2'b10, 38'h00_0000_0001};
        vecs[2] = '{2'b00, 38'h20_0000_0001, M_LOOP,   2'b01, 38'h00_0000_0002};
        vecs[3] = '{2'b00, 38'h3F_FFFF_FFFF, M_ZERO,   2'b11, 38'h00_0000_0000};
        vecs[4] = '{2'b10, 38'h2A_DEAD_BEEF, M_LOOP,   2'b10, 38'h15_BD5B_7DDE};
        vecs[5] = '{2'b10, 38'h00_1234_5678, M_ONES,   2'b01, 38'h3F_FFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_rti", {63'd0, vji_rti}, 64'd1);
        check("rst_tck", {63'd0, vji_tck}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_dr", {26'd0, rsp_dr}, 64'd0);
        check("rst_flags", {60'd0, vji_uir, vji_cdr, vji_sdr, vji_udr}, 64'd0);
        check("rst_ir_in", {62'd0, vji_ir_in}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        m_vld    = 1'b0;
        m_ir     = '0;
        m_ir_out = '0;
        for (int i = 0; i < 6; i++) begin
            mode       = vecs[i].mode;
            vji_ir_out = vecs[i].ir_out;
            skip = CACHE && m_vld && (vecs[i].ir == m_ir);
            if (!skip) begin
                m_vld    = 1'b1;
                m_ir     = vecs[i].ir;
                m_ir_out = vecs[i].ir_out;
            end
            off = skip ? 4 : 0;
            run_cmd(vecs[i].ir, vecs[i].dr, lat, acc_wait, rv_after);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(165 - off));
            check($sformatf("v%0d_rsp_dr", i), {26'd0, rsp_dr}, {26'd0, vecs[i].exp_dr});
            check($sformatf("v%0d_rsp_ir_out", i), {62'd0, rsp_ir_out}, {62'd0, m_ir_out});
            check($sformatf("v%0d_ir_in_clk1", i), {62'd0, ir_at1}, {62'd0, vecs[i].ir});
            check($sformatf("v%0d_tdi_seq", i), {26'd0, tdi_cap}, {26'd0, vecs[i].dr});
            check($sformatf("v%0d_uir_win", i), {uir_f, uir_l}, skip ? {-32'sd1, -32'sd1} : {32'd1, 32'd4});
            check($sformatf("v%0d_cdr_win", i), {cdr_f, cdr_l}, {32'(5 - off), 32'(8 - off)});
            check($sformatf("v%0d_sdr_win", i), {sdr_f, sdr_l}, {32'(9 - off), 32'(160 - off)});
            check($sformatf("v%0d_udr_win", i), {udr_f, udr_l}, {32'(161 - off), 32'(164 - off)});
            check($sformatf("v%0d_resp_tck_rti", i), {62'd0, vji_tck, vji_rti}, 64'd1);
            if (i > 0) begin
                check($sformatf("v%0d_b2b_wait", i), 64'(acc_wait), 64'd2);
                check($sformatf("v%0d_rv_pulse", i), {63'd0, rv_after}, 64'd0);
            end
        end

        // Response must be held after the one-clock pulse; IR stays on ir_in.
        @(posedge clk);
        #1;
        check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("hold_rsp_dr", {26'd0, rsp_dr}, {26'd0, vecs[5].exp_dr});
        check("hold_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("hold_ir_in", {62'd0, vji_ir_in}, {62'd0, vecs[5].ir});
        check("idle_tck_rti", {62'd0, vji_tck, vji_rti}, 64'd1);

        // Abort at clk 50 of a scan.
        mode       = M_LOOP;
        vji_ir_out = 2'b11;
        @(negedge clk);
        cmd_ir    = 2'b01;
        cmd_dr    = 38'h15_5555_AAAA;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (48) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_tck", {63'd0, vji_tck}, 64'd0);
        check("abort_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("abort_rti_sdr", {62'd0, vji_rti, vji_sdr}, 64'd2);
        check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rv_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (rsp_valid) rv_seen++;
        end
        check("abort_no_rsp", 64'(rv_seen), 64'd0);

        run_cmd(2'b01, 38'h15_5555_AAAA, lat, acc_wait, rv_after);
        check("post_abort_latency", 64'(lat), 64'd165);
        check("post_abort_rsp_dr", {26'd0, rsp_dr}, {26'd0, 38'h2A_AAAB_5554});
        check("post_abort_ir_out", {62'd0, rsp_ir_out}, 64'd3);
        check("post_abort_uir_win", {uir_f, uir_l}, {32'd1, 32'd4});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
